// File: rtl/vx_launch_pkg.sv
// Shared launch-controller types: FSM states and the DCR launch-write table.
package vx_launch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DCR_WR,
      DCR_GAP,
      RELEASE,
      WAIT_HI,
      WAIT_LO,
      FINISH
   } launch_state_e;

   // Number of DCR writes issued per launch.
   localparam int unsigned DCR_WR_COUNT = 5;

   localparam logic [11:0] DCR_STARTUP_ADDR0 = 12'h001;
   localparam logic [11:0] DCR_STARTUP_ADDR1 = 12'h002;
   localparam logic [11:0] DCR_STARTUP_ARG0  = 12'h003;
   localparam logic [11:0] DCR_STARTUP_ARG1  = 12'h004;
   localparam logic [11:0] DCR_MPM_CLASS     = 12'h005;

   // DCR address of write number idx in the launch sequence.
   function automatic logic [11:0] dcr_addr(input logic [2:0] idx);
      logic [11:0] a;
      case (idx)
         3'd0:    a = DCR_STARTUP_ADDR0;
         3'd1:    a = DCR_STARTUP_ADDR1;
         3'd2:    a = DCR_STARTUP_ARG0;
         3'd3:    a = DCR_STARTUP_ARG1;
         default: a = DCR_MPM_CLASS;
      endcase
      return a;
   endfunction

   // DCR data of write number idx; the final write carries zero.
   function automatic logic [31:0] dcr_data(input logic [2:0]  idx,
                                            input logic [63:0] startup,
                                            input logic [63:0] arg);
      logic [31:0] d;
      case (idx)
         3'd0:    d = startup[31:0];
         3'd1:    d = startup[63:32];
         3'd2:    d = arg[31:0];
         3'd3:    d = arg[63:32];
         default: d = 32'h0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/vx_launch_timer.sv
// Saturating down-counter used for the start-wait and run-timeout windows.
module vx_launch_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load has priority; decrement stops at zero instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/vx_launch_ctrl.sv
// Kernel launch controller: programs the Vortex startup DCRs, releases the GPU
// from reset and watches busy for completion or timeout.
module vx_launch_ctrl
   import vx_launch_pkg::*;
#(
   parameter int unsigned DCR_ADDR_W = 12,
   parameter int unsigned DCR_DATA_W = 32,
   parameter int unsigned TMR_W      = 24,
   parameter int unsigned START_WAIT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [63:0]           cmd_startup_addr,
   input  logic [63:0]           cmd_kernel_arg,
   input  logic [TMR_W-1:0]      cmd_timeout,
   output logic                  dcr_wr_valid,
   output logic [DCR_ADDR_W-1:0] dcr_wr_addr,
   output logic [DCR_DATA_W-1:0] dcr_wr_data,
   output logic                  gpu_reset,
   input  logic                  gpu_busy,
   output logic                  done,
   output logic                  timeout,
   output logic                  active
);

   launch_state_e    state_q;
   logic [63:0]      startup_q;
   logic [63:0]      arg_q;
   logic [TMR_W-1:0] timeout_q;
   logic [2:0]       wr_idx_q;
   logic [2:0]       wr_idx_nxt;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic             tmr_en;
   logic [TMR_W-1:0] unused_tmr_count;
   logic             tmr_zero;

   assign wr_idx_nxt = wr_idx_q + 3'd1;
   assign active     = (state_q != IDLE);

   // Start-wait window is armed in RELEASE; the run window on the busy rise.
   always_comb begin
      tmr_load     = (state_q == RELEASE) || ((state_q == WAIT_HI) && gpu_busy);
      tmr_load_val = (state_q == RELEASE) ? TMR_W'(START_WAIT) : timeout_q;
      tmr_en       = (state_q == WAIT_HI) || (state_q == WAIT_LO);
   end

   vx_launch_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .count    (unused_tmr_count),
      .zero     (tmr_zero)
   );

   // Launch sequencer with all handshake and GPU-facing outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         startup_q    <= '0;
         arg_q        <= '0;
         timeout_q    <= '0;
         wr_idx_q     <= '0;
         cmd_ready    <= 1'b0;
         dcr_wr_valid <= 1'b0;
         dcr_wr_addr  <= '0;
         dcr_wr_data  <= '0;
         gpu_reset    <= 1'b1;
         done         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  startup_q    <= cmd_startup_addr;
                  arg_q        <= cmd_kernel_arg;
                  timeout_q    <= cmd_timeout;
                  wr_idx_q     <= 3'd0;
                  cmd_ready    <= 1'b0;
                  gpu_reset    <= 1'b1;
                  // First write takes its data straight from the command.
                  dcr_wr_valid <= 1'b1;
                  dcr_wr_addr  <= DCR_ADDR_W'(dcr_addr(3'd0));
                  dcr_wr_data  <= DCR_DATA_W'(dcr_data(3'd0, cmd_startup_addr, cmd_kernel_arg));
                  state_q      <= DCR_WR;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            DCR_WR: begin
               dcr_wr_valid <= 1'b0;
               state_q      <= DCR_GAP;
            end
            DCR_GAP: begin
               if (wr_idx_q == 3'(DCR_WR_COUNT - 1)) begin
                  gpu_reset <= 1'b0;
                  state_q   <= RELEASE;
               end else begin
                  wr_idx_q     <= wr_idx_nxt;
                  dcr_wr_valid <= 1'b1;
                  dcr_wr_addr  <= DCR_ADDR_W'(dcr_addr(wr_idx_nxt));
                  dcr_wr_data  <= DCR_DATA_W'(dcr_data(wr_idx_nxt, startup_q, arg_q));
                  state_q      <= DCR_WR;
               end
            end
            RELEASE: begin
               state_q <= WAIT_HI;
            end
            WAIT_HI: begin
               if (gpu_busy) begin
                  state_q <= WAIT_LO;
               end else if (tmr_zero) begin
                  timeout   <= 1'b1;
                  gpu_reset <= 1'b1;
                  state_q   <= FINISH;
               end
            end
            WAIT_LO: begin
               // Busy falling wins over a same-cycle expiry.
               if (!gpu_busy) begin
                  done    <= 1'b1;
                  state_q <= FINISH;
               end else if ((timeout_q != '0) && tmr_zero) begin
                  timeout   <= 1'b1;
                  gpu_reset <= 1'b1;
                  state_q   <= FINISH;
               end
            end
            FINISH: begin
               cmd_ready <= 1'b1;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/vx_launch_ctrl.md
VX_LAUNCH_CTRL -- requirements
Module: vx_launch_ctrl

Interface
REQ-001 SHALL have parameter DCR_ADDR_W, default 12, DCR address width.
REQ-002 SHALL have parameter DCR_DATA_W, default 32, DCR data width.
REQ-003 SHALL have parameter TMR_W, default 24, width of the run-timeout counter.
REQ-004 SHALL have parameter START_WAIT, default 64, maximum cycles from GPU reset release to busy rising.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1, launch request.
REQ-008 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-009 SHALL have port cmd_startup_addr, input, 64, kernel entry PC.
REQ-010 SHALL have port cmd_kernel_arg, input, 64, kernel argument pointer.
REQ-011 SHALL have port cmd_timeout, input, TMR_W, maximum run cycles; 0 means no timeout.
REQ-012 SHALL have ports dcr_wr_valid (1), dcr_wr_addr (DCR_ADDR_W) and dcr_wr_data (DCR_DATA_W), all outputs, forming the DCR write port to Vortex_axi.
REQ-013 SHALL have port gpu_reset, output, 1, drives the Vortex_axi reset.
REQ-014 SHALL have port gpu_busy, input, 1, the Vortex_axi busy output.
REQ-015 SHALL have ports done and timeout, outputs, 1 each, one-cycle completion pulses.
REQ-016 SHALL have port active, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL capture cmd_startup_addr, cmd_kernel_arg and cmd_timeout into registers on cycle T, where cmd_valid && cmd_ready; inputs are ignored while cmd_ready is 0.
REQ-018 SHALL use FSM states IDLE, DCR_WR, DCR_GAP, RELEASE, WAIT_HI, WAIT_LO and FINISH.
REQ-019 SHALL transition IDLE to DCR_WR on accept and assert gpu_reset=1 the cycle after accept.
REQ-020 SHALL issue five writes, each one cycle of dcr_wr_valid followed by one DCR_GAP cycle with valid=0, at T+1, T+3, T+5, T+7 and T+9.
REQ-021 SHALL use this write order: 0x001=startup[31:0], 0x002=startup[63:32], 0x003=arg[31:0], 0x004=arg[63:32], 0x005=0.
REQ-022 SHALL hold dcr_wr_addr and dcr_wr_data stable only while valid is high; their value is don't-care otherwise.
REQ-023 SHALL enter RELEASE at T+11 and drive gpu_reset=0 from T+11 onward.
REQ-024 SHALL load the run counter with START_WAIT in RELEASE, then enter WAIT_HI.
REQ-025 SHALL, in WAIT_HI, move to WAIT_LO and reload the counter with the latched timeout when gpu_busy=1; if the counter reaches 0 first, go to FINISH with timeout.
REQ-026 SHALL, in WAIT_LO, go to FINISH with done when gpu_busy=0; if the latched timeout is nonzero and the counter reaches 0 first, go to FINISH with timeout.
REQ-027 SHALL give priority to completion when gpu_busy falls in the same cycle the counter expires: done=1, timeout=0.
REQ-028 SHALL, in FINISH, pulse exactly one of done or timeout for one cycle, then return to IDLE.
REQ-029 SHALL keep gpu_reset=0 after done, and set gpu_reset=1 after timeout to hold the GPU quiesced.
REQ-030 SHALL decrement the counter with saturation at 0 and never wrap.
REQ-031 SHALL never assert done and timeout in the same cycle.

Reset
REQ-032 SHALL, while reset=1, force state=IDLE, gpu_reset=1, dcr_wr_valid=0, done=0, timeout=0, active=0, cmd_ready=0, and clear the counter and latched registers.
REQ-033 SHALL, on reset asserted mid-sequence, abort the sequence immediately with no further DCR writes and no done/timeout pulse.
REQ-034 SHALL raise cmd_ready on the first clock edge after reset deasserts.

Structure
REQ-035 SHALL place the state enum, DCR address constants 0x001–0x005 and the write count (5) in package vx_launch_pkg.
REQ-036 SHALL implement the saturating down-counter as sub-module vx_launch_timer, with inputs load, load_val and en, and outputs count and zero.

Verification
REQ-037 Normal launch: startup=0x80000000, arg=0x12000, timeout=1000; busy rises 3 cycles after release and falls 200 cycles later -> five writes exactly as REQ-020/021, gpu_reset low at T+11, done one cycle after busy falls.
REQ-038 Start timeout: gpu_busy held 0 -> timeout pulse at T+11+START_WAIT+1 (±1, documented), and gpu_reset=1 afterward.
REQ-039 Run timeout: timeout=100, busy held 1 -> timeout pulse after 100 WAIT_LO cycles; timeout=0 with busy held 1 for 5000 cycles -> no pulse.
REQ-040 Reset mid-sequence: assert reset at T+4 -> no write at 0x003, gpu_reset=1, and a fresh command completes normally.
REQ-041 Back-pressure and simultaneity: cmd_valid held high through the run -> exactly one accept per IDLE; busy falling on the expiry cycle -> done only.
